// File: rtl/histogram_scan_reader.sv
// histogram_scan_reader: walks every histogram bin through a one-cycle
// latency read port, streams (bin, count) beats on a valid/ready interface,
// and publishes the mode bin and total population with a done pulse.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting for start; results of the last scan are held
//   READ  | read strobe issued for the current bin pointer
//   WAIT  | read data arrives; capture beat, update running max and sum
//   OUT   | beat presented; advance on handshake, or finish after last
//   DONE  | one-cycle done pulse; results already latched
module histogram_scan_reader #(
  parameter int DATA_SIZE  = 4,
  parameter int DATA_NUM   = 16,
  parameter int COUNT_SIZE = 5,
  parameter int TOTAL_SIZE = COUNT_SIZE + DATA_SIZE
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  output logic                  busy,
  output logic                  hist_rd_en,
  output logic [DATA_SIZE-1:0]  hist_rd_addr,
  input  logic [COUNT_SIZE-1:0] hist_rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_SIZE-1:0]  out_bin,
  output logic [COUNT_SIZE-1:0] out_count,
  output logic                  out_last,
  output logic                  done,
  output logic [DATA_SIZE-1:0]  mode_bin,
  output logic [COUNT_SIZE-1:0] mode_count,
  output logic [TOTAL_SIZE-1:0] total
);

  localparam logic [DATA_SIZE-1:0] LAST_BIN = DATA_SIZE'(DATA_NUM - 1);

  typedef enum logic [2:0] {IDLE, READ, WAIT, OUT, DONE} state_t;

  state_t                  state, state_next;
  logic [DATA_SIZE-1:0]    ptr;
  logic [COUNT_SIZE-1:0]   run_max;
  logic [DATA_SIZE-1:0]    run_mode;
  logic [TOTAL_SIZE-1:0]   run_sum;
  logic                    clear;
  logic                    capture;
  logic                    advance;
  logic                    load_result;

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state and decoded outputs/datapath controls.
  always_comb begin
    state_next   = state;
    busy         = 1'b0;
    hist_rd_en   = 1'b0;
    hist_rd_addr = '0;
    out_valid    = 1'b0;
    out_last     = 1'b0;
    done         = 1'b0;
    clear        = 1'b0;
    capture      = 1'b0;
    advance      = 1'b0;
    load_result  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          clear      = 1'b1;
          state_next = READ;
        end
      end
      READ: begin
        busy         = 1'b1;
        hist_rd_en   = 1'b1;
        hist_rd_addr = ptr;
        state_next   = WAIT;
      end
      WAIT: begin
        busy       = 1'b1;
        capture    = 1'b1;
        state_next = OUT;
      end
      OUT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_last  = (ptr == LAST_BIN);
        if (out_ready) begin
          if (ptr == LAST_BIN) begin
            // Results go out with the done pulse, so latch on entry to DONE.
            load_result = 1'b1;
            state_next  = DONE;
          end else begin
            advance    = 1'b1;
            state_next = READ;
          end
        end
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Pointer, running accumulators, registered beat and published results.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr        <= '0;
      run_max    <= '0;
      run_mode   <= '0;
      run_sum    <= '0;
      out_bin    <= '0;
      out_count  <= '0;
      mode_bin   <= '0;
      mode_count <= '0;
      total      <= '0;
    end else begin
      if (clear) begin
        ptr      <= '0;
        run_max  <= '0;
        run_mode <= '0;
        run_sum  <= '0;
      end
      if (advance) ptr <= ptr + 1'b1;
      if (capture) begin
        out_count <= hist_rd_data;
        out_bin   <= ptr;
        run_sum   <= run_sum + TOTAL_SIZE'(hist_rd_data);
        // Strict compare: ties keep the earlier (lower) bin.
        if (hist_rd_data > run_max) begin
          run_max  <= hist_rd_data;
          run_mode <= ptr;
        end
      end
      if (load_result) begin
        mode_bin   <= run_mode;
        mode_count <= run_max;
        total      <= run_sum;
      end
    end
  end

endmodule

// File: tb/tb_histogram_scan_reader.sv
// Scoreboard bench for histogram_scan_reader: expected beats and results are
// queued when a scan is launched; a monitor pops and compares them.
module tb_histogram_scan_reader;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       start = 1'b0;
  logic       busy;
  logic       hist_rd_en;
  logic [3:0] hist_rd_addr;
  logic [4:0] hist_rd_data = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [3:0] out_bin;
  logic [4:0] out_count;
  logic       out_last;
  logic       done;
  logic [3:0] mode_bin;
  logic [4:0] mode_count;
  logic [8:0] total;

  histogram_scan_reader dut (
    .clk(clk), .rstn(rstn), .start(start), .busy(busy),
    .hist_rd_en(hist_rd_en), .hist_rd_addr(hist_rd_addr),
    .hist_rd_data(hist_rd_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_bin(out_bin), .out_count(out_count),
    .out_last(out_last), .done(done), .mode_bin(mode_bin),
    .mode_count(mode_count), .total(total)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] bin;
    logic [4:0] cnt;
    logic       last;
  } beat_t;

  typedef struct {
    logic [3:0] mb;
    logic [4:0] mc;
    logic [8:0] tot;
    int         cyc;
  } res_t;

  beat_t      beat_q[$];
  res_t       res_q[$];
  logic [4:0] mem[16];
  int         cyc = 0;
  int         base = 0;
  int         n_cmp = 0;
  int         n_err = 0;
  int         done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Histogram memory model with one-cycle read latency.
  always @(posedge clk) if (hist_rd_en) hist_rd_data <= mem[hist_rd_addr];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc - base);
    end
  endtask

  // Monitor: compare each accepted beat and each done pulse.
  always @(negedge clk) begin
    if (rstn && out_valid && out_ready) begin
      if (beat_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_beat: got bin %0d expected none", out_bin);
      end else begin
        beat_t b;
        b = beat_q.pop_front();
        chk("beat_bin", out_bin, b.bin);
        chk("beat_count", out_count, b.cnt);
        chk("beat_last", out_last, b.last);
      end
    end
    if (rstn && done) begin
      done_cnt++;
      if (res_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_done: got done expected none");
      end else begin
        res_t r;
        r = res_q.pop_front();
        chk("mode_bin", mode_bin, r.mb);
        chk("mode_count", mode_count, r.mc);
        chk("total", total, r.tot);
        chk("done_cycle", cyc - base, r.cyc);
      end
    end
  end

  // Called at posedge+1 while IDLE; returns in cycle 2 (+1).
  task automatic start_scan(input logic [3:0] mb, input logic [4:0] mc,
                            input logic [8:0] tot, input int dcyc);
    res_t r;
    for (int i = 0; i < 16; i++) beat_q.push_back('{bin: 4'(i), cnt: mem[i], last: (i == 15)});
    r.mb = mb; r.mc = mc; r.tot = tot; r.cyc = dcyc;
    res_q.push_back(r);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    base = cyc - 1;
    chk("c1_busy", busy, 1);
    chk("c1_rd_en", hist_rd_en, 1);
    chk("c1_rd_addr", hist_rd_addr, 0);
    @(posedge clk); #1;
    chk("c2_rd_idle", {hist_rd_en, hist_rd_addr}, 0);
  endtask

  task automatic wait_cycle(input int n);
    while ((cyc - base) < n) begin @(posedge clk); #1; end
  endtask

  // Waits for the done pulse (bounded), then checks IDLE in the next cycle.
  task automatic wait_done();
    int seen = done_cnt;
    int n = 0;
    while (done_cnt == seen && n < 200) begin @(negedge clk); #1; n++; end
    if (done_cnt == seen) begin
      n_cmp++; n_err++;
      $display("FAIL done_timeout: got no done expected done within 200 cycles");
    end
    @(posedge clk); #1;
    chk("idle_busy", {busy, done}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", {busy, hist_rd_en, hist_rd_addr, out_valid, out_bin, out_count,
                       out_last, done, mode_bin, mode_count, total}, 0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // All bins zero.
    for (int i = 0; i < 16; i++) mem[i] = 5'd0;
    start_scan(4'd0, 5'd0, 9'd0, 49);
    wait_done();

    // Bins 5 and 9 tie at 7, lower index wins.
    for (int i = 0; i < 16; i++) mem[i] = (i == 5 || i == 9) ? 5'd7 : 5'd1;
    start_scan(4'd5, 5'd7, 9'd28, 49);
    wait_done();

    // Full-scale counts, no wrap of the sum.
    for (int i = 0; i < 16; i++) mem[i] = 5'd31;
    start_scan(4'd0, 5'd31, 9'd496, 49);
    wait_done();

    // Backpressure on bin 3 for five OUT cycles.
    for (int i = 0; i < 16; i++) mem[i] = 5'(i + 1);
    start_scan(4'd15, 5'd16, 9'd136, 54);
    wait_cycle(11);
    out_ready = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", out_valid, 1);
      chk("stall_hold", {out_bin, out_count}, {4'd3, 5'd4});
      chk("stall_no_rd", hist_rd_en, 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_done();

    // Start pulses mid-scan are ignored.
    for (int i = 0; i < 16; i++) mem[i] = 5'(15 - i);
    start_scan(4'd0, 5'd15, 9'd120, 49);
    wait_cycle(10);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_cycle(30);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done();
    repeat (4) begin
      @(posedge clk); #1;
      chk("no_restart", {busy, done}, 0);
    end

    // Reset while bin 8 is presented, then rescan.
    for (int i = 0; i < 16; i++) mem[i] = 5'd2;
    start_scan(4'd0, 5'd2, 9'd32, 49);
    wait_cycle(27);
    chk("pre_reset_bin", {out_valid, out_bin}, {1'b1, 4'd8});
    rstn = 1'b0;
    #1;
    beat_q.delete();
    res_q.delete();
    chk("midreset_outs", {busy, hist_rd_en, hist_rd_addr, out_valid, out_bin, out_count,
                          out_last, done, mode_bin, mode_count, total}, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hold_outs", {busy, out_valid, out_bin, out_count, mode_bin, mode_count, total}, 0);
    rstn = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) mem[i] = (i == 12) ? 5'd20 : 5'd3;
    start_scan(4'd12, 5'd20, 9'd65, 49);
    wait_cycle(20);
    chk("results_cleared", {mode_bin, mode_count, total}, 0);
    wait_done();

    chk("beat_q_empty", beat_q.size(), 0);
    chk("res_q_empty", res_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
